// File: rtl/ahb_cmd_pkg.sv
// ahb_cmd_pkg
//   Shared encodings and lookups for the AHB command issuer:
//   HTRANS / HBURST / HSIZE constants, FSM state codes, and the
//   burst-type -> beat-count and burst-type -> wrap-mask helpers.
package ahb_cmd_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   // Beats per command; undefined-length INCR uses the configured length.
   function automatic logic [4:0] beat_count(input logic [2:0] burst,
                                             input logic [4:0] incr_len);
      logic [4:0] n;
      case (burst)
         HBURST_SINGLE:               n = 5'd1;
         HBURST_INCR:                 n = incr_len;
         HBURST_WRAP4,  HBURST_INCR4:  n = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  n = 5'd8;
         default:                     n = 5'd16;
      endcase
      return n;
   endfunction

   function automatic logic is_wrap(input logic [2:0] burst);
      return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) ||
             (burst == HBURST_WRAP16);
   endfunction

   // Byte mask of the wrap window (span-1); zero for non-wrapping bursts.
   function automatic logic [5:0] wrap_mask(input logic [2:0] burst);
      logic [5:0] m;
      case (burst)
         HBURST_WRAP4:  m = 6'h0F;
         HBURST_WRAP8:  m = 6'h1F;
         HBURST_WRAP16: m = 6'h3F;
         default:       m = 6'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen
//   Combinational next-beat address generator.
//   Ports:
//     haddr          - current beat address (word aligned)
//     hburst         - current burst type
//     next_addr      - address of the following beat
//     boundary_cross - incrementing burst steps onto a 1 KB boundary,
//                      so the next beat must restart as NONSEQ/INCR
module ahb_addr_gen
   import ahb_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [2:0]            hburst,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  boundary_cross
);

   logic [ADDR_WIDTH-1:0] inc;
   logic [ADDR_WIDTH-1:0] mask;
   logic                  wrap;

   assign inc  = haddr + ADDR_WIDTH'(4);
   assign mask = {{(ADDR_WIDTH-6){1'b0}}, wrap_mask(hburst)};
   assign wrap = is_wrap(hburst);

   always_comb begin
      next_addr      = inc;
      boundary_cross = 1'b0;
      if (wrap) begin
         // Wrap windows are naturally aligned, never straddle 1 KB.
         next_addr = (haddr & ~mask) | (inc & mask);
      end else begin
         boundary_cross = (inc[9:0] == 10'd0);
      end
   end

endmodule

// File: rtl/ahb_cmd_issuer.sv
// ahb_cmd_issuer
//   Pops one command from the command FIFO and expands it into AHB-Lite
//   address-phase beats, honouring HREADY.
//   Ports:
//     R_CLK, R_RST_N            - clock, async active-low reset
//     FIFO_EMPTY, i_rfifo_*     - FIFO head command and empty flag
//     R_EN                      - pop strobe (combinational, IDLE only)
//     HREADY                    - AHB ready
//     HTRANS/HADDR/HWRITE/HBURST/HSIZE - address phase
//     o_busy                    - command in flight (ISSUE + GAP)
//     o_beat_accept             - address beat accepted this cycle
//     o_cmd_done                - last beat accepted this cycle
module ahb_cmd_issuer
   import ahb_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int INCR_LEN   = 4
) (
   input  logic                  R_CLK,
   input  logic                  R_RST_N,
   input  logic                  FIFO_EMPTY,
   input  logic                  i_rfifo_write,
   input  logic [2:0]            i_rfifo_user_burst_type,
   input  logic [ADDR_WIDTH-1:0] i_rfifo_user_addr,
   output logic                  R_EN,
   input  logic                  HREADY,
   output logic [1:0]            HTRANS,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HBURST,
   output logic [2:0]            HSIZE,
   output logic                  o_busy,
   output logic                  o_beat_accept,
   output logic                  o_cmd_done
);

   logic [1:0]            state;
   logic [4:0]            beat_cnt;
   logic [4:0]            cmd_len;
   logic                  nonseq_q;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  boundary_cross;
   logic                  last_beat;

   ahb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .haddr          (HADDR),
      .hburst         (HBURST),
      .next_addr      (next_addr),
      .boundary_cross (boundary_cross)
   );

   assign R_EN          = (state == ST_IDLE) && !FIFO_EMPTY;
   assign HTRANS        = (state != ST_ISSUE) ? HTRANS_IDLE :
                          (nonseq_q ? HTRANS_NONSEQ : HTRANS_SEQ);
   assign HSIZE         = HSIZE_WORD;
   assign o_busy        = (state != ST_IDLE);
   assign o_beat_accept = (state == ST_ISSUE) && HREADY;
   assign last_beat     = (beat_cnt == cmd_len - 5'd1);
   assign o_cmd_done    = o_beat_accept && last_beat;

   always_ff @(posedge R_CLK or negedge R_RST_N) begin
      if (!R_RST_N) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         cmd_len  <= '0;
         nonseq_q <= 1'b0;
         HADDR    <= '0;
         HWRITE   <= 1'b0;
         HBURST   <= HBURST_SINGLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!FIFO_EMPTY) begin
                  state    <= ST_ISSUE;
                  HADDR    <= i_rfifo_user_addr & ~ADDR_WIDTH'(3);
                  HWRITE   <= i_rfifo_write;
                  HBURST   <= i_rfifo_user_burst_type;
                  beat_cnt <= '0;
                  cmd_len  <= beat_count(i_rfifo_user_burst_type, 5'(INCR_LEN));
                  nonseq_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // HREADY low freezes address, burst and counter.
               if (HREADY) begin
                  if (last_beat) begin
                     state <= ST_GAP;
                  end else begin
                     beat_cnt <= beat_cnt + 5'd1;
                     HADDR    <= next_addr;
                     // Crossing 1 KB restarts the remainder as undefined INCR.
                     nonseq_q <= boundary_cross;
                     if (boundary_cross) HBURST <= HBURST_INCR;
                  end
               end
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
